// File: rtl/watch_mode_controller.sv
// Button conditioning and mode/edit state machine for the watch datapath.
// The datapath sees only one-cycle command pulses and level controls, never raw buttons.
//
// mode state     | meaning
// MODE_TIMER     | countdown control: start, pause, clear
// MODE_STOPWATCH | stopwatch control: run toggle, lap, clear
// MODE_CLOCK     | time of day; a long split press enters field edit
// MODE_SET_ALARM | alarm time; start/stop arms the alarm, a long split press enters field edit
module watch_mode_controller #(
   parameter int DEBOUNCE_CYCLES   = 2,
   parameter int LONG_PRESS_CYCLES = 200
) (
   input  logic       clockSignal,
   input  logic       resetSignal,
   input  logic       btnMode,
   input  logic       btnStartStop,
   input  logic       btnSplitReset,
   input  logic       countdownActive,
   input  logic       alarmRinging,
   output logic [1:0] mode,
   output logic [1:0] editField,
   output logic       timerStartPulse,
   output logic       timerPausePulse,
   output logic       timerClearPulse,
   output logic       swRunToggle,
   output logic       lapPulse,
   output logic       swClearPulse,
   output logic       editIncPulse,
   output logic       alarmAckPulse,
   output logic       alarmEnable
);

   localparam int DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam int LPW = $clog2(LONG_PRESS_CYCLES + 1);

   typedef enum logic [1:0] {
      MODE_TIMER     = 2'd0,
      MODE_STOPWATCH = 2'd1,
      MODE_CLOCK     = 2'd2,
      MODE_SET_ALARM = 2'd3
   } mode_t;

   // Bit 0 = mode, bit 1 = start/stop, bit 2 = split/reset.
   logic [2:0]     w_raw;
   logic [2:0]     r_sync1;
   logic [2:0]     r_sync2;
   logic [2:0]     r_deb;
   logic [2:0]     r_deb_d;
   logic [DBW-1:0] r_db_cnt [3];
   logic [LPW-1:0] r_lp_cnt;
   logic           r_long_fired;

   logic w_mode_press;
   logic w_ss_press;
   logic w_short;
   logic w_long;
   logic w_split_evt;
   logic w_any_evt;

   mode_t      r_mode;
   mode_t      w_mode_nxt;
   logic [1:0] r_edit;
   logic [1:0] w_edit_nxt;
   logic       r_sw_running;
   logic       w_sw_running_nxt;
   logic       r_alarm_en;
   logic       w_alarm_en_nxt;
   logic       r_tstart, r_tpause, r_tclear, r_swtog, r_lap, r_swclr, r_inc, r_ack;
   logic       w_tstart, w_tpause, w_tclear, w_swtog, w_lap, w_swclr, w_inc, w_ack;

   assign w_raw = {btnSplitReset, btnStartStop, btnMode};

   // The counter only advances while the synchronised level disagrees with the debounced one.
   always_ff @(posedge clockSignal or posedge resetSignal) begin
      if (resetSignal) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[i]    <= ~r_deb[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_mode_press = r_deb[0] & ~r_deb_d[0];
   assign w_ss_press   = r_deb[1] & ~r_deb_d[1];
   assign w_long       = r_deb[2] & ~r_long_fired & (r_lp_cnt == LPW'(LONG_PRESS_CYCLES - 1));
   assign w_short      = ~r_deb[2] & r_deb_d[2] & ~r_long_fired;
   assign w_split_evt  = w_short | w_long;
   assign w_any_evt    = w_mode_press | w_ss_press | w_split_evt;

   always_ff @(posedge clockSignal or posedge resetSignal) begin
      if (resetSignal) begin
         r_lp_cnt     <= '0;
         r_long_fired <= 1'b0;
      end else if (!r_deb[2]) begin
         r_lp_cnt     <= '0;
         r_long_fired <= 1'b0;
      end else begin
         if (r_lp_cnt != LPW'(LONG_PRESS_CYCLES)) r_lp_cnt <= r_lp_cnt + 1'b1;
         if (w_long) r_long_fired <= 1'b1;
      end
   end

   always_ff @(posedge clockSignal or posedge resetSignal) begin
      if (resetSignal) begin
         r_mode       <= MODE_TIMER;
         r_edit       <= 2'd0;
         r_sw_running <= 1'b0;
         r_alarm_en   <= 1'b0;
         r_tstart     <= 1'b0;
         r_tpause     <= 1'b0;
         r_tclear     <= 1'b0;
         r_swtog      <= 1'b0;
         r_lap        <= 1'b0;
         r_swclr      <= 1'b0;
         r_inc        <= 1'b0;
         r_ack        <= 1'b0;
      end else begin
         r_mode       <= w_mode_nxt;
         r_edit       <= w_edit_nxt;
         r_sw_running <= w_sw_running_nxt;
         r_alarm_en   <= w_alarm_en_nxt;
         r_tstart     <= w_tstart;
         r_tpause     <= w_tpause;
         r_tclear     <= w_tclear;
         r_swtog      <= w_swtog;
         r_lap        <= w_lap;
         r_swclr      <= w_swclr;
         r_inc        <= w_inc;
         r_ack        <= w_ack;
      end
   end

   // One event per cycle; a ringing alarm swallows whatever arrives.
   always_comb begin
      w_mode_nxt       = r_mode;
      w_edit_nxt       = r_edit;
      w_sw_running_nxt = r_sw_running;
      w_alarm_en_nxt   = r_alarm_en;
      w_tstart         = 1'b0;
      w_tpause         = 1'b0;
      w_tclear         = 1'b0;
      w_swtog          = 1'b0;
      w_lap            = 1'b0;
      w_swclr          = 1'b0;
      w_inc            = 1'b0;
      w_ack            = 1'b0;
      if (alarmRinging && w_any_evt) begin
         w_ack = 1'b1;
      end else if (w_mode_press) begin
         w_mode_nxt = mode_t'(r_mode + 2'd1);
         w_edit_nxt = 2'd0;
      end else if (w_split_evt) begin
         case (r_mode)
            MODE_TIMER: w_tclear = 1'b1;
            MODE_STOPWATCH: begin
               if (w_long) begin
                  w_swclr          = 1'b1;
                  w_sw_running_nxt = 1'b0;
               end else if (r_sw_running) begin
                  w_lap = 1'b1;
               end else begin
                  w_swclr = 1'b1;
               end
            end
            default: begin
               if (r_edit == 2'd0) begin
                  if (w_long) w_edit_nxt = 2'd1;
               end else if (w_long) begin
                  w_edit_nxt = 2'd0;
               end else begin
                  w_edit_nxt = r_edit + 2'd1;
               end
            end
         endcase
      end else if (w_ss_press) begin
         case (r_mode)
            MODE_TIMER: begin
               if (countdownActive) w_tpause = 1'b1;
               else                 w_tstart = 1'b1;
            end
            MODE_STOPWATCH: begin
               w_swtog          = 1'b1;
               w_sw_running_nxt = ~r_sw_running;
            end
            MODE_CLOCK: begin
               if (r_edit != 2'd0) w_inc = 1'b1;
            end
            default: begin
               if (r_edit != 2'd0) w_inc = 1'b1;
               else                w_alarm_en_nxt = ~r_alarm_en;
            end
         endcase
      end
   end

   assign mode            = r_mode;
   assign editField       = r_edit;
   assign timerStartPulse = r_tstart;
   assign timerPausePulse = r_tpause;
   assign timerClearPulse = r_tclear;
   assign swRunToggle     = r_swtog;
   assign lapPulse        = r_lap;
   assign swClearPulse    = r_swclr;
   assign editIncPulse    = r_inc;
   assign alarmAckPulse   = r_ack;
   assign alarmEnable     = r_alarm_en;

endmodule

// File: tb/tb_watch_mode_controller.sv
// Directed bench for watch_mode_controller: timing of press/long/short events and mode actions.
module tb_watch_mode_controller;

   logic       clockSignal = 1'b0;
   logic       resetSignal;
   logic       btnMode, btnStartStop, btnSplitReset;
   logic       countdownActive, alarmRinging;
   logic [1:0] mode, editField;
   logic       timerStartPulse, timerPausePulse, timerClearPulse;
   logic       swRunToggle, lapPulse, swClearPulse, editIncPulse, alarmAckPulse, alarmEnable;

   int checks   = 0;
   int failures = 0;

   int n_tstart = 0, n_tpause = 0, n_tclear = 0, n_swtog = 0;
   int n_lap = 0, n_swclr = 0, n_inc = 0, n_ack = 0;

   watch_mode_controller dut (
      .clockSignal     (clockSignal),
      .resetSignal     (resetSignal),
      .btnMode         (btnMode),
      .btnStartStop    (btnStartStop),
      .btnSplitReset   (btnSplitReset),
      .countdownActive (countdownActive),
      .alarmRinging    (alarmRinging),
      .mode            (mode),
      .editField       (editField),
      .timerStartPulse (timerStartPulse),
      .timerPausePulse (timerPausePulse),
      .timerClearPulse (timerClearPulse),
      .swRunToggle     (swRunToggle),
      .lapPulse        (lapPulse),
      .swClearPulse    (swClearPulse),
      .editIncPulse    (editIncPulse),
      .alarmAckPulse   (alarmAckPulse),
      .alarmEnable     (alarmEnable)
   );

   always #5 clockSignal = ~clockSignal;

   // Pulse tallies, one per high cycle, so a delta of 1 also proves single-cycle width.
   always @(negedge clockSignal) begin
      if (timerStartPulse) n_tstart++;
      if (timerPausePulse) n_tpause++;
      if (timerClearPulse) n_tclear++;
      if (swRunToggle)     n_swtog++;
      if (lapPulse)        n_lap++;
      if (swClearPulse)    n_swclr++;
      if (editIncPulse)    n_inc++;
      if (alarmAckPulse)   n_ack++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clockSignal);
      #1;
   endtask

   // which: 0 mode, 1 start/stop, 2 split/reset. Settles long enough for release debounce.
   task automatic press(input int which, input int hold);
      case (which)
         0: btnMode = 1'b1;
         1: btnStartStop = 1'b1;
         default: btnSplitReset = 1'b1;
      endcase
      cyc(hold);
      btnMode       = 1'b0;
      btnStartStop  = 1'b0;
      btnSplitReset = 1'b0;
      cyc(8);
   endtask

   task automatic test_reset;
      resetSignal = 1'b1;
      cyc(3);
      checks++;
      if ({mode, editField, alarmEnable} !== 5'd0) begin
         failures++;
         $display("FAIL reset_levels got=%b exp=00000", {mode, editField, alarmEnable});
      end
      checks++;
      if ({timerStartPulse, timerPausePulse, timerClearPulse, swRunToggle, lapPulse,
           swClearPulse, editIncPulse, alarmAckPulse} !== 8'd0) begin
         failures++;
         $display("FAIL reset_pulses got=%b exp=00000000",
                  {timerStartPulse, timerPausePulse, timerClearPulse, swRunToggle, lapPulse,
                   swClearPulse, editIncPulse, alarmAckPulse});
      end
      resetSignal = 1'b0;
      cyc(2);
   endtask

   task automatic test_mode_cycle;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] e_prev, e_new;
         e_prev = 2'(i);
         e_new  = 2'(i + 1);
         btnMode = 1'b1;
         cyc(4);
         checks++;
         if (mode !== e_prev) begin
            failures++;
            $display("FAIL mode_early step=%0d got=%0d exp=%0d", i, mode, e_prev);
         end
         cyc(1);
         checks++;
         if (mode !== e_new) begin
            failures++;
            $display("FAIL mode_step step=%0d got=%0d exp=%0d", i, mode, e_new);
         end
         btnMode = 1'b0;
         cyc(8);
      end
   endtask

   task automatic test_timer;
      int b_ts, b_tp, b_tc;
      b_ts = n_tstart;
      btnStartStop = 1'b1;
      cyc(1);
      btnStartStop = 1'b0;
      cyc(8);
      checks++;
      if (n_tstart != b_ts) begin
         failures++;
         $display("FAIL glitch_start got=%0d exp=0", n_tstart - b_ts);
      end
      b_ts = n_tstart; b_tp = n_tpause;
      countdownActive = 1'b0;
      press(1, 5);
      checks++;
      if (n_tstart - b_ts != 1 || n_tpause != b_tp) begin
         failures++;
         $display("FAIL timer_start start=%0d pause=%0d exp=1,0", n_tstart - b_ts, n_tpause - b_tp);
      end
      b_ts = n_tstart; b_tp = n_tpause;
      countdownActive = 1'b1;
      press(1, 5);
      checks++;
      if (n_tpause - b_tp != 1 || n_tstart != b_ts) begin
         failures++;
         $display("FAIL timer_pause start=%0d pause=%0d exp=0,1", n_tstart - b_ts, n_tpause - b_tp);
      end
      countdownActive = 1'b0;
      b_tc = n_tclear;
      press(2, 10);
      checks++;
      if (n_tclear - b_tc != 1) begin
         failures++;
         $display("FAIL timer_clear got=%0d exp=1", n_tclear - b_tc);
      end
   endtask

   task automatic test_stopwatch;
      int b_tog, b_lap, b_clr;
      press(0, 5);
      checks++;
      if (mode !== 2'd1) begin
         failures++;
         $display("FAIL sw_mode got=%0d exp=1", mode);
      end
      b_tog = n_swtog;
      press(1, 5);
      checks++;
      if (n_swtog - b_tog != 1) begin
         failures++;
         $display("FAIL sw_toggle got=%0d exp=1", n_swtog - b_tog);
      end
      b_lap = n_lap; b_clr = n_swclr;
      btnSplitReset = 1'b1;
      cyc(50);
      checks++;
      if (n_lap != b_lap) begin
         failures++;
         $display("FAIL lap_on_press got=%0d exp=0", n_lap - b_lap);
      end
      btnSplitReset = 1'b0;
      cyc(8);
      checks++;
      if (n_lap - b_lap != 1 || n_swclr != b_clr) begin
         failures++;
         $display("FAIL lap_on_release lap=%0d clr=%0d exp=1,0", n_lap - b_lap, n_swclr - b_clr);
      end
      press(1, 5);
      b_lap = n_lap; b_clr = n_swclr;
      press(2, 10);
      checks++;
      if (n_swclr - b_clr != 1 || n_lap != b_lap) begin
         failures++;
         $display("FAIL sw_short_clear clr=%0d lap=%0d exp=1,0", n_swclr - b_clr, n_lap - b_lap);
      end
      press(1, 5);
      b_lap = n_lap; b_clr = n_swclr;
      btnSplitReset = 1'b1;
      cyc(203);
      checks++;
      if (swClearPulse !== 1'b0) begin
         failures++;
         $display("FAIL long_early got=%b exp=0", swClearPulse);
      end
      cyc(1);
      checks++;
      if (swClearPulse !== 1'b1) begin
         failures++;
         $display("FAIL long_threshold got=%b exp=1", swClearPulse);
      end
      cyc(46);
      btnSplitReset = 1'b0;
      cyc(8);
      checks++;
      if (n_swclr - b_clr != 1 || n_lap != b_lap) begin
         failures++;
         $display("FAIL long_release clr=%0d lap=%0d exp=1,0", n_swclr - b_clr, n_lap - b_lap);
      end
      b_lap = n_lap; b_clr = n_swclr;
      press(2, 10);
      checks++;
      if (n_swclr - b_clr != 1 || n_lap != b_lap) begin
         failures++;
         $display("FAIL long_stops_run clr=%0d lap=%0d exp=1,0", n_swclr - b_clr, n_lap - b_lap);
      end
   endtask

   task automatic test_edit;
      int b_inc;
      press(0, 5);
      b_inc = n_inc;
      press(1, 5);
      checks++;
      if (mode !== 2'd2 || n_inc != b_inc || alarmEnable !== 1'b0) begin
         failures++;
         $display("FAIL clock_ss_ignored mode=%0d inc=%0d en=%b exp=2,0,0", mode, n_inc - b_inc, alarmEnable);
      end
      press(2, 250);
      checks++;
      if (editField !== 2'd1) begin
         failures++;
         $display("FAIL clock_enter_edit got=%0d exp=1", editField);
      end
      b_inc = n_inc;
      for (int i = 0; i < 3; i++) press(1, 5);
      checks++;
      if (n_inc - b_inc != 3) begin
         failures++;
         $display("FAIL edit_inc got=%0d exp=3", n_inc - b_inc);
      end
      for (int i = 0; i < 3; i++) begin
         logic [1:0] e_f;
         e_f = 2'(i + 2);
         press(2, 10);
         checks++;
         if (editField !== e_f) begin
            failures++;
            $display("FAIL edit_advance step=%0d got=%0d exp=%0d", i, editField, e_f);
         end
      end
      press(2, 250);
      press(0, 5);
      checks++;
      if (mode !== 2'd3 || editField !== 2'd0) begin
         failures++;
         $display("FAIL mode_exits_edit mode=%0d field=%0d exp=3,0", mode, editField);
      end
      press(1, 5);
      checks++;
      if (alarmEnable !== 1'b1) begin
         failures++;
         $display("FAIL alarm_arm got=%b exp=1", alarmEnable);
      end
      press(2, 250);
      b_inc = n_inc;
      press(1, 5);
      checks++;
      if (editField !== 2'd1 || n_inc - b_inc != 1 || alarmEnable !== 1'b1) begin
         failures++;
         $display("FAIL alarm_edit_inc field=%0d inc=%0d en=%b exp=1,1,1", editField, n_inc - b_inc, alarmEnable);
      end
      press(2, 250);
      checks++;
      if (editField !== 2'd0) begin
         failures++;
         $display("FAIL long_exits_edit got=%0d exp=0", editField);
      end
      press(0, 5);
   endtask

   task automatic test_alarm_priority;
      int b_ack, b_ts;
      b_ack = n_ack; b_ts = n_tstart;
      alarmRinging = 1'b1;
      btnMode      = 1'b1;
      btnStartStop = 1'b1;
      cyc(5);
      checks++;
      if (alarmAckPulse !== 1'b1) begin
         failures++;
         $display("FAIL ack_timing got=%b exp=1", alarmAckPulse);
      end
      btnMode      = 1'b0;
      btnStartStop = 1'b0;
      cyc(8);
      checks++;
      if (n_ack - b_ack != 1 || mode !== 2'd0 || n_tstart != b_ts) begin
         failures++;
         $display("FAIL ack_only ack=%0d mode=%0d start=%0d exp=1,0,0", n_ack - b_ack, mode, n_tstart - b_ts);
      end
      alarmRinging = 1'b0;
   endtask

   task automatic test_reset_midhold;
      int b_tc, b_clr, b_lap;
      press(0, 5);
      press(1, 5);
      btnSplitReset = 1'b1;
      cyc(124);
      resetSignal = 1'b1;
      #1;
      checks++;
      if ({mode, editField, alarmEnable, timerStartPulse, timerPausePulse, timerClearPulse,
           swRunToggle, lapPulse, swClearPulse, editIncPulse, alarmAckPulse} !== 13'd0) begin
         failures++;
         $display("FAIL midhold_reset got=%b exp=0",
                  {mode, editField, alarmEnable, timerStartPulse, timerPausePulse, timerClearPulse,
                   swRunToggle, lapPulse, swClearPulse, editIncPulse, alarmAckPulse});
      end
      cyc(3);
      resetSignal = 1'b0;
      b_tc = n_tclear;
      cyc(203);
      checks++;
      if (timerClearPulse !== 1'b0 || n_tclear != b_tc) begin
         failures++;
         $display("FAIL fresh_long_early pulse=%b count=%0d exp=0,0", timerClearPulse, n_tclear - b_tc);
      end
      cyc(1);
      checks++;
      if (timerClearPulse !== 1'b1) begin
         failures++;
         $display("FAIL fresh_long_threshold got=%b exp=1", timerClearPulse);
      end
      cyc(20);
      btnSplitReset = 1'b0;
      cyc(8);
      checks++;
      if (n_tclear - b_tc != 1) begin
         failures++;
         $display("FAIL fresh_long_count got=%0d exp=1", n_tclear - b_tc);
      end
      press(0, 5);
      b_clr = n_swclr; b_lap = n_lap;
      press(2, 10);
      checks++;
      if (n_swclr - b_clr != 1 || n_lap != b_lap) begin
         failures++;
         $display("FAIL reset_clears_run clr=%0d lap=%0d exp=1,0", n_swclr - b_clr, n_lap - b_lap);
      end
   endtask

   initial begin
      resetSignal     = 1'b1;
      btnMode         = 1'b0;
      btnStartStop    = 1'b0;
      btnSplitReset   = 1'b0;
      countdownActive = 1'b0;
      alarmRinging    = 1'b0;
      test_reset;
      test_mode_cycle;
      test_timer;
      test_stopwatch;
      test_edit;
      test_alarm_priority;
      test_reset_midhold;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
